// File: rtl/calc_pkg.sv
// Shared types for the calculator datapath and output driver.
// Opcodes, FSM states and counter sizing.
package calc_pkg;

  localparam int OP_W   = 2;
  localparam int DATA_W = 16;

  function automatic int cnt_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  localparam int CNT_W = cnt_w(DATA_W);

  typedef enum logic [OP_W-1:0] {
    ADD, SUB, MUL, DIV
  } op_e;

  typedef enum logic [2:0] {
    IDLE, ADDSUB, ITER, FIX, DONE
  } alu_state_e;

endpackage

// File: rtl/calc_alu_mul_div.sv
// Shared hi/lo shift datapath: shift-add multiply and
// restoring divide on unsigned magnitudes, one bit per step.
module mul_div_unit
  import calc_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    step,
  input  op_e                     op,
  input  logic [DATA_WIDTH-1:0]   a,
  input  logic [DATA_WIDTH-1:0]   b,
  output logic [2*DATA_WIDTH-1:0] product,
  output logic [DATA_WIDTH-1:0]   quotient
);

  localparam int W = DATA_WIDTH;

  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic [W-1:0] opnd;
  logic [W:0]   sum;
  logic [W:0]   shifted;
  logic [W-1:0] rem;
  logic         borrow;

  always_comb begin
    sum     = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
    shifted = {hi, lo[W-1]};
    borrow  = shifted < {1'b0, opnd};
    rem     = shifted[W-1:0] - opnd;
  end

  // lo holds the multiplier (MUL) or dividend/quotient (DIV)
  always_ff @(posedge clk) begin
    if (rst) begin
      hi   <= '0;
      lo   <= '0;
      opnd <= '0;
    end else if (start) begin
      hi   <= '0;
      lo   <= a;
      opnd <= b;
    end else if (step) begin
      if (op == DIV) begin
        hi <= borrow ? shifted[W-1:0] : rem;
        lo <= {lo[W-2:0], ~borrow};
      end else begin
        {hi, lo} <= {sum, lo[W-1:1]};
      end
    end
  end

  assign product  = {hi, lo};
  assign quotient = lo;

endmodule

// File: rtl/calc_alu.sv
// Multi-cycle calculator ALU: ADD/SUB in one cycle, MUL/DIV
// iterated bit-serially, result held until downstream accepts.
module calc_alu
  import calc_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  input  logic [OP_W-1:0]       i_op,
  input  logic                  i_2s_comp,
  input  logic                  i_valid,
  output logic                  o_ready,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_2s_comp,
  output logic                  o_error,
  output logic                  o_valid,
  input  logic                  i_ready
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = cnt_w(W);

  alu_state_e state, next;

  logic [CW-1:0]  cnt;
  logic [W-1:0]   a_q, b_q;
  op_e            op_q;
  logic           sgn_q;
  logic           accept, last, neg;
  logic           step, load;
  logic [W-1:0]   a_mag, b_mag;
  logic [2*W-1:0] product, prod_s;
  logic [W-1:0]   quotient, quo_s;
  logic [W:0]     sum, dif;
  logic [W-1:0]   res;
  logic           err;

  assign accept = i_valid && o_ready;
  assign last   = cnt == CW'(W-1);
  assign neg    = sgn_q && (a_q[W-1] ^ b_q[W-1]);
  assign a_mag  = (i_2s_comp && i_a[W-1]) ? -i_a : i_a;
  assign b_mag  = (i_2s_comp && i_b[W-1]) ? -i_b : i_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      o_ready <= 1'b0;
      o_valid <= 1'b0;
    end else begin
      state   <= next;
      o_ready <= next == IDLE;
      o_valid <= next == DONE;
    end
  end

  always_comb begin
    next = state;
    unique case (state)
      IDLE:    if (accept) next = i_op[1] ? ITER : ADDSUB;
      ADDSUB:  next = DONE;
      ITER:    if (last) next = FIX;
      FIX:     next = DONE;
      DONE:    if (i_ready) next = IDLE;
      default: next = IDLE;
    endcase
  end

  always_comb begin
    step   = state == ITER;
    load   = (state == ADDSUB) || (state == FIX);
    sum    = {1'b0, a_q} + {1'b0, b_q};
    dif    = {1'b0, a_q} - {1'b0, b_q};
    prod_s = neg ? -product : product;
    quo_s  = neg ? -quotient : quotient;
    res    = '0;
    err    = 1'b0;
    unique case (1'b1)
      op_q == ADD: begin
        res = sum[W-1:0];
        err = sgn_q ? (a_q[W-1] == b_q[W-1] && sum[W-1] != a_q[W-1])
                    : sum[W];
      end
      op_q == SUB: begin
        res = dif[W-1:0];
        err = sgn_q ? (a_q[W-1] != b_q[W-1] && dif[W-1] != a_q[W-1])
                    : dif[W];
      end
      op_q == MUL: begin
        res = prod_s[W-1:0];
        err = sgn_q ? (prod_s[2*W-1:W] != {W{prod_s[W-1]}})
                    : (|prod_s[2*W-1:W]);
      end
      default: begin
        res = quo_s;
        err = (b_q == '0) ||
              (sgn_q && a_q == {1'b1, {(W-1){1'b0}}} && (&b_q));
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= ADD;
      sgn_q     <= 1'b0;
      cnt       <= '0;
      o_data    <= '0;
      o_error   <= 1'b0;
      o_2s_comp <= 1'b0;
    end else begin
      if (accept) begin
        a_q   <= i_a;
        b_q   <= i_b;
        op_q  <= op_e'(i_op);
        sgn_q <= i_2s_comp;
        cnt   <= '0;
      end
      if (step) cnt <= cnt + 1'b1;
      if (load) begin
        o_data    <= err ? '0 : res;
        o_error   <= err;
        o_2s_comp <= sgn_q;
      end
    end
  end

  mul_div_unit #(
    .DATA_WIDTH(W)
  ) u_mul_div (
    .clk     (clk),
    .rst     (rst),
    .start   (accept),
    .step    (step),
    .op      (op_q),
    .a       (a_mag),
    .b       (b_mag),
    .product (product),
    .quotient(quotient)
  );

endmodule

// File: tb/tb_calc_alu.sv
// Bench for calc_alu: directed cases plus random bundles
// checked against an integer-arithmetic reference model.
module tb_calc_alu;
  import calc_pkg::*;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] i_a, i_b;
  logic [1:0]   i_op;
  logic         i_2s_comp, i_valid, i_ready;
  logic         o_ready, o_2s_comp, o_error, o_valid;
  logic [W-1:0] o_data;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  calc_alu #(.DATA_WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .i_a      (i_a),
    .i_b      (i_b),
    .i_op     (i_op),
    .i_2s_comp(i_2s_comp),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .o_data   (o_data),
    .o_2s_comp(o_2s_comp),
    .o_error  (o_error),
    .o_valid  (o_valid),
    .i_ready  (i_ready)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic void model(input logic [W-1:0] a,
                                input logic [W-1:0] b,
                                input logic [1:0] op,
                                input logic sgn,
                                output logic [W-1:0] d,
                                output logic e);
    longint x, y, r;
    bit bad;
    x   = sgn ? longint'($signed(a)) : longint'(a);
    y   = sgn ? longint'($signed(b)) : longint'(b);
    bad = 0;
    r   = 0;
    case (op)
      2'd0: r = x + y;
      2'd1: r = x - y;
      2'd2: r = x * y;
      default:
        if (y == 0) bad = 1;
        else r = x / y;
    endcase
    if (sgn) bad = bad || r < -32768 || r > 32767;
    else     bad = bad || r < 0 || r > 65535;
    d = bad ? '0 : r[W-1:0];
    e = bad;
  endfunction

  task automatic run_op(input logic [W-1:0] a,
                        input logic [W-1:0] b,
                        input logic [1:0] op,
                        input logic sgn,
                        input int hold);
    logic [W-1:0] ed;
    logic ee;
    int n;
    model(a, b, op, sgn, ed, ee);
    n = 0;
    while (!o_ready && n < 50) begin
      tick;
      n++;
    end
    check("ready_idle", o_ready, 1);
    i_a = a;
    i_b = b;
    i_op = op;
    i_2s_comp = sgn;
    i_valid = 1'b1;
    i_ready = (hold == 0);
    tick;
    i_valid = 1'b0;
    i_a = W'($urandom);
    i_b = W'($urandom);
    i_op = 2'($urandom);
    i_2s_comp = 1'($urandom);
    check("busy_ready", o_ready, 0);
    n = 0;
    while (!o_valid && n < 50) begin
      tick;
      n++;
    end
    check("latency", n, op[1] ? W + 1 : 1);
    check("data", o_data, ed);
    check("error", o_error, ee);
    check("sign", o_2s_comp, sgn);
    if (hold > 0) begin
      i_valid = 1'b1;
      repeat (hold) begin
        tick;
        check("hold_valid", o_valid, 1);
        check("hold_ready", o_ready, 0);
        check("hold_data", o_data, ed);
        check("hold_error", o_error, ee);
        check("hold_sign", o_2s_comp, sgn);
      end
      i_ready = 1'b1;
      tick;
      i_valid = 1'b0;
    end else begin
      tick;
    end
    check("release_valid", o_valid, 0);
    check("release_ready", o_ready, 1);
  endtask

  initial begin
    rst = 1'b1;
    i_a = '0;
    i_b = '0;
    i_op = '0;
    i_2s_comp = 1'b0;
    i_valid = 1'b0;
    i_ready = 1'b1;
    repeat (3) tick;
    check("rst_ready", o_ready, 0);
    check("rst_valid", o_valid, 0);
    check("rst_data", o_data, 0);
    check("rst_error", o_error, 0);
    check("rst_sign", o_2s_comp, 0);
    rst = 1'b0;
    tick;
    check("post_rst_ready", o_ready, 1);

    run_op(16'd40000, 16'd30000, ADD, 1'b0, 0);
    run_op(16'd1200, 16'd34, ADD, 1'b0, 0);
    run_op(16'd5, 16'd9, SUB, 1'b1, 0);
    run_op(16'h8000, 16'd1, SUB, 1'b1, 0);
    run_op(16'hFF85, 16'd45, MUL, 1'b1, 0);
    run_op(16'd300, 16'd300, MUL, 1'b0, 0);
    run_op(16'hFF9C, 16'd7, DIV, 1'b1, 0);
    run_op(16'd100, 16'd0, DIV, 1'b0, 0);
    run_op(16'h8000, 16'hFFFF, DIV, 1'b1, 0);
    run_op(16'hFFFB, 16'd3, MUL, 1'b1, 5);
    run_op(16'd1234, 16'd4321, ADD, 1'b0, 5);

    i_a = 16'd77;
    i_b = 16'd91;
    i_op = MUL;
    i_2s_comp = 1'b0;
    i_valid = 1'b1;
    tick;
    i_valid = 1'b0;
    repeat (5) tick;
    rst = 1'b1;
    tick;
    check("abort_valid", o_valid, 0);
    check("abort_data", o_data, 0);
    check("abort_error", o_error, 0);
    check("abort_ready", o_ready, 0);
    rst = 1'b0;
    tick;
    check("abort_ready_next", o_ready, 1);
    run_op(16'd2, 16'd3, ADD, 1'b0, 0);

    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] ra, rb;
      ra = W'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 20))
                                       : W'($urandom);
      if ($urandom_range(0, 2) == 0) ra = W'($urandom_range(0, 300));
      run_op(ra, rb, 2'($urandom), 1'($urandom),
             int'($urandom_range(0, 2)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
